wb_arbiter: RTL and testbench



---
 rtl/mips_pkg.sv | 15 +
 rtl/wb_arbiter_if.sv | 32 +++
 rtl/wb_fifo.sv | 64 ++++++
 rtl/wb_arbiter.sv | 126 ++++++++++++
 tb/tb_wb_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions used by the write-back path.
package mips_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 5;

  // Register 0 is hardwired to zero, so writes to it are dropped.
  localparam int unsigned REG_ZERO = 0;

  typedef struct packed {
    logic [DEF_DEPTH-1:0] wr;
    logic [DEF_WIDTH-1:0] wd;
  } wb_req_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Write-back bus: ALU source, multi-cycle source and register-file write port.
interface wb_arbiter_if #(
  parameter int WIDTH = mips_pkg::DEF_WIDTH,
  parameter int DEPTH = mips_pkg::DEF_DEPTH
);

  logic                  a_valid;
  logic [DEPTH-1:0]      a_wr;
  logic [WIDTH-1:0]      a_wd;
  logic                  a_stall;
  logic                  b_valid;
  logic                  b_ready;
  logic [DEPTH-1:0]      b_wr;
  logic [WIDTH-1:0]      b_wd;
  logic                  RegWrite;
  logic [DEPTH-1:0]      WR;
  logic [WIDTH-1:0]      WD;
  logic [(1<<DEPTH)-1:0] busy;

  // Pipeline side: drives requests, observes the write port and scoreboard.
  modport master (
    output a_valid, a_wr, a_wd, b_valid, b_wr, b_wd,
    input  a_stall, b_ready, RegWrite, WR, WD, busy
  );

  // Arbiter side.
  modport slave (
    input  a_valid, a_wr, a_wd, b_valid, b_wr, b_wd,
    output a_stall, b_ready, RegWrite, WR, WD, busy
  );

endinterface

// File: rtl/wb_fifo.sv
// In-order buffer for multi-cycle results with a pending-destination vector.
module wb_fifo
  import mips_pkg::*;
#(
  parameter type req_t      = wb_req_t,
  parameter int  DEPTH      = DEF_DEPTH,
  parameter int  FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  req_t                          push_data,
  input  logic                          pop,
  output req_t                          head,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          empty,
  output logic [(1<<DEPTH)-1:0]         busy
);

  localparam int PW = $clog2(FIFO_DEPTH);

  req_t                  mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] vld;
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;

  // Pointers, occupancy and per-entry valid flags; pointers wrap since depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      vld   <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop)  vld[rptr] <= 1'b0;
      if (push) vld[wptr] <= 1'b1;
    end
  end

  // Entry payloads need no reset; the valid flags say which slots are live.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_data;
  end

  assign head  = mem[rptr];
  assign empty = (count == '0);

  // One bit per register still owed a write by some live entry.
  always_comb begin
    busy = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (vld[i]) busy[mem[i].wr] = 1'b1;
    end
    busy[0] = 1'b0;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Merges the ALU and multi-cycle write-back streams onto the single register-file write port.
module wb_arbiter
  import mips_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);

  typedef struct packed {
    logic [DEPTH-1:0] wr;
    logic [WIDTH-1:0] wd;
  } req_t;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

  req_t                  b_req;
  req_t                  head;
  logic [CW-1:0]         count;
  logic                  empty;
  logic [(1<<DEPTH)-1:0] fifo_busy;
  logic [(1<<DEPTH)-1:0] busy_c;
  logic                  push;
  logic                  pop;
  logic                  a_write;
  logic                  force_q;
  logic                  force_d;
  logic [SW-1:0]         starve_q;
  logic [SW-1:0]         starve_d;
  logic                  reg_write_q;
  logic [DEPTH-1:0]      wr_q;
  logic [WIDTH-1:0]      wd_q;
  logic                  from_b_q;

  assign b_req.wr = bus.b_wr;
  assign b_req.wd = bus.b_wd;

  // Readiness ignores a same-cycle dequeue so a full buffer never accepts.
  assign bus.b_ready = (count != CW'(FIFO_DEPTH));
  assign push        = bus.b_valid && bus.b_ready && (bus.b_wr != DEPTH'(REG_ZERO));

  // A register-0 ALU result is consumed without taking the write slot.
  assign a_write = bus.a_valid && !force_q && (bus.a_wr != DEPTH'(REG_ZERO));
  assign pop     = !empty && (force_q || !a_write);

  wb_fifo #(
    .req_t      (req_t),
    .DEPTH      (DEPTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (b_req),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .busy      (fifo_busy)
  );

  // Count ALU wins over a waiting head; the limit-th win schedules one forced dequeue.
  always_comb begin
    force_d  = 1'b0;
    starve_d = starve_q;
    if (pop || empty) begin
      starve_d = '0;
    end else if (a_write) begin
      if (starve_q == SW'(STARVE_LIMIT - 1)) begin
        force_d  = 1'b1;
        starve_d = '0;
      end else begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  // Starvation state and the registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      force_q     <= 1'b0;
      starve_q    <= '0;
      reg_write_q <= 1'b0;
      wr_q        <= '0;
      wd_q        <= '0;
      from_b_q    <= 1'b0;
    end else begin
      force_q  <= force_d;
      starve_q <= starve_d;
      if (pop) begin
        reg_write_q <= 1'b1;
        wr_q        <= head.wr;
        wd_q        <= head.wd;
        from_b_q    <= 1'b1;
      end else if (a_write) begin
        reg_write_q <= 1'b1;
        wr_q        <= bus.a_wr;
        wd_q        <= bus.a_wd;
        from_b_q    <= 1'b0;
      end else begin
        reg_write_q <= 1'b0;
        from_b_q    <= 1'b0;
      end
    end
  end

  // A dequeued entry stays busy while its write sits on the port, until the file has it.
  always_comb begin
    busy_c = fifo_busy;
    if (reg_write_q && from_b_q) busy_c[wr_q] = 1'b1;
    busy_c[0] = 1'b0;
  end

  assign bus.busy     = busy_c;
  assign bus.a_stall  = force_q;
  assign bus.RegWrite = reg_write_q;
  assign bus.WR       = wr_q;
  assign bus.WD       = wd_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a per-cycle expectation scoreboard.
module tb_wb_arbiter;

  localparam int W   = 32;
  localparam int D   = 5;
  localparam int FD  = 4;
  localparam int LIM = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  wb_arbiter_if #(.WIDTH(W), .DEPTH(D)) bus ();

  wb_arbiter #(
    .WIDTH        (W),
    .DEPTH        (D),
    .FIFO_DEPTH   (FD),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [D-1:0] wr;
    logic [W-1:0] wd;
  } req_s;

  typedef struct {
    bit                we;
    logic [D-1:0]      wr;
    logic [W-1:0]      wd;
    logic [(1<<D)-1:0] busy;
    bit                stall;
    bit                rdy;
  } exp_s;

  req_s mq[$];
  exp_s sb[$];
  int   mStarve;
  bit   mForce;
  int   errors = 0;
  int   checks = 0;
  int   bSeen  = 0;
  bit   aTaken;
  bit   bTaken;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    sb.delete();
    mStarve = 0;
    mForce  = 1'b0;
  endtask

  // Drives one cycle of requests and pushes what the port must show after the next edge.
  task automatic applyStimulus(input bit av, input logic [D-1:0] awr, input logic [W-1:0] awd,
                               input bit bv, input logic [D-1:0] bwr, input logic [W-1:0] bwd,
                               output bit aT, output bit bT);
    exp_s e;
    req_s r;
    bit   wasEmpty;
    bit   popped;
    bit   fromB;
    bit   aOk;
    bit   bRdy;
    bit   nForce;
    bus.a_valid = av;
    bus.a_wr    = awr;
    bus.a_wd    = awd;
    bus.b_valid = bv;
    bus.b_wr    = bwr;
    bus.b_wd    = bwd;
    wasEmpty = (mq.size() == 0);
    bRdy     = (mq.size() != FD);
    aOk      = av && !mForce && (awr != '0);
    popped   = 1'b0;
    fromB    = 1'b0;
    nForce   = 1'b0;
    e.we     = 1'b0;
    e.wr     = '0;
    e.wd     = '0;
    if (mForce && !wasEmpty) begin
      r = mq.pop_front(); e.we = 1'b1; e.wr = r.wr; e.wd = r.wd; popped = 1'b1; fromB = 1'b1;
    end else if (aOk) begin
      e.we = 1'b1; e.wr = awr; e.wd = awd;
    end else if (!wasEmpty) begin
      r = mq.pop_front(); e.we = 1'b1; e.wr = r.wr; e.wd = r.wd; popped = 1'b1; fromB = 1'b1;
    end
    if (popped || wasEmpty) begin
      mStarve = 0;
    end else if (aOk) begin
      if (mStarve == LIM - 1) begin
        nForce  = 1'b1;
        mStarve = 0;
      end else begin
        mStarve++;
      end
    end
    aT     = av && !mForce;
    mForce = nForce;
    bT     = bv && bRdy;
    if (bT && bwr != '0) begin
      r.wr = bwr;
      r.wd = bwd;
      mq.push_back(r);
    end
    e.busy = '0;
    foreach (mq[i]) e.busy[mq[i].wr] = 1'b1;
    if (e.we && fromB) e.busy[e.wr] = 1'b1;
    e.busy[0] = 1'b0;
    e.stall   = mForce;
    e.rdy     = (mq.size() != FD);
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_s e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL sb_underflow observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    if (bus.RegWrite && bus.WR >= 5'd10 && bus.WR <= 5'd14) bSeen++;
    chk("regwrite", 64'(bus.RegWrite), 64'(e.we));
    if (e.we) begin
      chk("wr", 64'(bus.WR), 64'(e.wr));
      chk("wd", 64'(bus.WD), 64'(e.wd));
    end
    chk("busy",    64'(bus.busy),    64'(e.busy));
    chk("a_stall", 64'(bus.a_stall), 64'(e.stall));
    chk("b_ready", 64'(bus.b_ready), 64'(e.rdy));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, aTaken, bTaken);
      tick();
    end
  endtask

  // Bounds the whole run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    int bIdx;
    int acceptAt;
    int aIdx;
    rst         = 1'b1;
    bus.a_valid = 1'b0;
    bus.a_wr    = '0;
    bus.a_wd    = '0;
    bus.b_valid = 1'b0;
    bus.b_wr    = '0;
    bus.b_wd    = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regwrite", 64'(bus.RegWrite), 64'd0);
    chk("rst_wr",       64'(bus.WR),       64'd0);
    chk("rst_wd",       64'(bus.WD),       64'd0);
    chk("rst_busy",     64'(bus.busy),     64'd0);
    chk("rst_a_stall",  64'(bus.a_stall),  64'd0);
    chk("rst_b_ready",  64'(bus.b_ready),  64'd1);
    rst = 1'b0;
    idle(2);

    $display("[TB] A only");
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, aTaken, bTaken);
    tick();
    chk("a_only_we", 64'(bus.RegWrite), 64'd1);
    chk("a_only_wr", 64'(bus.WR),       64'd5);
    chk("a_only_wd", 64'(bus.WD),       64'hDEADBEEF);
    applyStimulus(1'b1, 5'd0, 32'h12345678, 1'b0, '0, '0, aTaken, bTaken);
    tick();
    chk("a_reg0_no_write", 64'(bus.RegWrite), 64'd0);
    idle(1);

    $display("[TB] B only");
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd7, 32'h11, aTaken, bTaken);
    tick();
    chk("b_no_bypass", 64'(bus.RegWrite), 64'd0);
    chk("b_busy7_set", 64'(bus.busy[7]),  64'd1);
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd8, 32'h22, aTaken, bTaken);
    tick();
    chk("b_first_wr", 64'(bus.WR),        64'd7);
    chk("b_busy_87",  64'(bus.busy[8:7]), 64'b11);
    idle(1);
    chk("b_second_wr", 64'(bus.WR),        64'd8);
    chk("b_busy_8",    64'(bus.busy[8:7]), 64'b10);
    idle(1);
    chk("b_busy_clear", 64'(bus.busy[8:7]), 64'b00);

    $display("[TB] full buffer");
    bSeen    = 0;
    bIdx     = 0;
    acceptAt = -1;
    for (int c = 0; c < 30 && bIdx < 5; c++) begin
      applyStimulus(1'b1, 5'd3, 32'hA0000003, 1'b1, 5'(10 + bIdx), 32'hB0000000 + bIdx,
                    aTaken, bTaken);
      if (bTaken) begin
        bIdx++;
        if (bIdx == 5) acceptAt = c;
      end
      tick();
      if (c == 3) chk("full_b_ready_low", 64'(bus.b_ready), 64'd0);
    end
    chk("full_all_accepted", 64'(bIdx),     64'd5);
    chk("full_5th_cycle",    64'(acceptAt), 64'd5);
    for (int c = 0; c < 40 && (mq.size() != 0 || mForce); c++) begin
      applyStimulus(1'b1, 5'd3, 32'hA0000003, 1'b0, '0, '0, aTaken, bTaken);
      tick();
    end
    idle(2);
    chk("full_no_loss_dup", 64'(bSeen),    64'd5);
    chk("full_busy_clear",  64'(bus.busy), 64'd0);

    $display("[TB] starvation");
    aIdx = 0;
    for (int c = 0; c < 7; c++) begin
      applyStimulus(1'b1, 5'(21 + aIdx), 32'hC0000000 + aIdx, c == 0, 5'd20, 32'h5A5A0020,
                    aTaken, bTaken);
      if (aTaken) aIdx++;
      tick();
      if (c == 2) chk("starve_no_stall_yet", 64'(bus.a_stall), 64'd0);
      if (c == 3) chk("starve_stall_on",     64'(bus.a_stall), 64'd1);
      if (c == 4) begin
        chk("starve_b_wr",      64'(bus.WR),      64'd20);
        chk("starve_b_wd",      64'(bus.WD),      64'h5A5A0020);
        chk("starve_stall_off", 64'(bus.a_stall), 64'd0);
      end
      if (c == 5) begin
        chk("starve_resume_wr", 64'(bus.WR), 64'd25);
        chk("starve_resume_wd", 64'(bus.WD), 64'hC0000004);
      end
    end
    idle(2);

    $display("[TB] duplicate destination");
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 32'hD0, aTaken, bTaken);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 32'hD1, aTaken, bTaken);
    tick();
    chk("dup_busy_first", 64'(bus.busy[9]), 64'd1);
    idle(1);
    chk("dup_second_wd",  64'(bus.WD),      64'hD1);
    chk("dup_busy_held",  64'(bus.busy[9]), 64'd1);
    idle(1);
    chk("dup_busy_clear", 64'(bus.busy[9]), 64'd0);

    $display("[TB] reset mid-operation");
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 5'd2, 32'hF0000000 + c, c < 3, 5'(12 + c), 32'hE0 + c,
                    aTaken, bTaken);
      tick();
    end
    chk("rst_pre_busy",  64'(bus.busy[14:12]), 64'b111);
    chk("rst_pre_stall", 64'(bus.a_stall),     64'd1);
    applyStimulus(1'b1, 5'd2, 32'hF0000009, 1'b0, '0, '0, aTaken, bTaken);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async_regwrite", 64'(bus.RegWrite), 64'd0);
    chk("rst_async_busy",     64'(bus.busy),     64'd0);
    chk("rst_async_stall",    64'(bus.a_stall),  64'd0);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    idle(4);
    chk("rst_after_b_ready", 64'(bus.b_ready), 64'd1);
    chk("rst_sb_drained",    64'(sb.size()),   64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
